// File: rtl/lfsr_card_pkg.sv
// Shared types and helpers for the LFSR card-draw block.
// Optional lockup guard in lfsr_core: LFSR_LOCKUP_GUARD_EN.
package lfsr_card_pkg;

  typedef logic [3:0] rank_t;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_e;

  localparam rank_t RANK_MIN = 4'd1;
  localparam rank_t RANK_MAX = 4'd13;

  localparam logic [31:0] DEFAULT_TAPS32 = 32'h8020_0003;

  // Last-try mapping of a rejected nibble onto a legal rank
  function automatic rank_t fallback_rank(input rank_t cand);
    rank_t r;
    unique case (cand)
      4'd14:   r = 4'd1;
      4'd15:   r = 4'd2;
      default: r = RANK_MAX;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lfsr_card_draw_core.sv
// Galois LFSR register with seed load and step enable.
// Define LFSR_LOCKUP_GUARD_EN to keep the state out of all-zero.
module lfsr_core
  import lfsr_card_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [63:0] TAPS  = 64'(DEFAULT_TAPS32),
  parameter logic [63:0] SEED  = 64'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAP_W  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;

  assign w_shift = (r_state >> 1) ^ (r_state[0] ? TAP_W : '0);

`ifdef LFSR_LOCKUP_GUARD_EN
  assign w_next = (w_shift == '0) ? SEED_W : w_shift;
  assign w_load = (load_val == '0) ? SEED_W : load_val;
`else
  assign w_next = w_shift;
  assign w_load = load_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_W;
    end else if (load) begin
      r_state <= w_load;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/lfsr_card_draw.sv
// LFSR with a rejection-sampling card-draw FSM (ranks 1..13).
// Lockup guard selectable with LFSR_LOCKUP_GUARD_EN (see lfsr_core).
module lfsr_card_draw
  import lfsr_card_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [63:0] TAPS      = 64'(DEFAULT_TAPS32),
  parameter logic [63:0] SEED      = 64'h1,
  parameter int          MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             draw_req,
  output logic             draw_ready,
  output logic             card_valid,
  output logic [3:0]       card_rank,
  output logic [WIDTH-1:0] randnum
);

  localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);

  draw_state_e      r_fsm;
  logic [7:0]       r_tries;
  logic             r_valid;
  rank_t            r_rank;
  logic [WIDTH-1:0] w_state;
  logic             w_step;
  rank_t            w_cand;
  logic             w_ok;

  assign w_step = en | (r_fsm == DRAW);
  assign w_cand = w_state[3:0];
  assign w_ok   = (w_cand >= RANK_MIN) && (w_cand <= RANK_MAX);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .step     (w_step),
    .load     (seed_ld),
    .load_val (seed_in),
    .state    (w_state)
  );

  // A seed load in DRAW freezes evaluation for that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_tries <= '0;
      r_valid <= 1'b0;
      r_rank  <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          if (draw_req) begin
            r_fsm   <= DRAW;
            r_tries <= '0;
          end
        end
        DRAW: begin
          if (!seed_ld) begin
            if (w_ok) begin
              r_rank  <= w_cand;
              r_valid <= 1'b1;
              r_fsm   <= IDLE;
            end else if (r_tries == TRY_LAST) begin
              r_rank  <= fallback_rank(w_cand);
              r_valid <= 1'b1;
              r_fsm   <= IDLE;
            end else begin
              r_tries <= r_tries + 8'd1;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign draw_ready = (r_fsm == IDLE);
  assign card_valid = r_valid;
  assign card_rank  = r_rank;
  assign randnum    = w_state;

endmodule
